slot_dispatcher: RTL and testbench

- Consumer end of the slot table: walks slots 0..2^INDEX_WIDTH-1 through the table's read-index/mux port.
- For each PENDING slot: requests reconfiguration when the slot's profile differs from the loaded one, issues a DMA command (addr/size), waits for completion, then writes final status back through the table's set_status port.
- Sits between the slot table, the DFX reconfiguration controller and the DMA command engine.

---
 rtl/slot_dispatcher_if.sv | 50 +++++
 rtl/slot_dispatcher.sv | 190 +++++++++++++++++++
 tb/tb_slot_dispatcher.sv | 347 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_dispatcher_if.sv
// Slot table, reconfiguration and DMA command bus seen by slot_dispatcher.
// The master modport is the dispatcher side and the slave modport is the environment side.
interface slot_dispatcher_if #(
  parameter int unsigned INDEX_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned SIZE_WIDTH    = 26,
  parameter int unsigned STATUS_WIDTH  = 2,
  parameter int unsigned PROFILE_WIDTH = 4
);
  logic [INDEX_WIDTH-1:0]   rd_index;
  logic [ADDR_WIDTH-1:0]    rd_addr;
  logic [SIZE_WIDTH-1:0]    rd_size;
  logic [STATUS_WIDTH-1:0]  rd_status;
  logic [PROFILE_WIDTH-1:0] rd_profile;

  logic [INDEX_WIDTH-1:0]   wr_index;
  logic [STATUS_WIDTH-1:0]  wr_status;
  logic                     wr_set_status;

  logic                     rcfg_req;
  logic [PROFILE_WIDTH-1:0] rcfg_profile;
  logic                     rcfg_ack;

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [ADDR_WIDTH-1:0]    cmd_addr;
  logic [SIZE_WIDTH-1:0]    cmd_size;
  logic                     cmd_done;
  logic                     cmd_err;

  modport master (
    output rd_index,
    input  rd_addr, rd_size, rd_status, rd_profile,
    output wr_index, wr_status, wr_set_status,
    output rcfg_req, rcfg_profile,
    input  rcfg_ack,
    output cmd_valid, cmd_addr, cmd_size,
    input  cmd_ready, cmd_done, cmd_err
  );

  modport slave (
    input  rd_index,
    output rd_addr, rd_size, rd_status, rd_profile,
    input  wr_index, wr_status, wr_set_status,
    input  rcfg_req, rcfg_profile,
    output rcfg_ack,
    input  cmd_valid, cmd_addr, cmd_size,
    output cmd_ready, cmd_done, cmd_err
  );
endinterface

// File: rtl/slot_dispatcher.sv
// Walks the slot table, reconfigures on profile change, dispatches one DMA command per
// PENDING slot and writes back DONE/ERROR. Define SLOT_DISP_LOOP_EN for continuous passes with stop.
module slot_dispatcher #(
  parameter int unsigned INDEX_WIDTH   = 2,
  parameter int unsigned ADDR_WIDTH    = 32,
  parameter int unsigned SIZE_WIDTH    = 26,
  parameter int unsigned STATUS_WIDTH  = 2,
  parameter int unsigned PROFILE_WIDTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
`ifdef SLOT_DISP_LOOP_EN
  input  logic stop,
`endif
  output logic busy,
  output logic pass_done,
  slot_dispatcher_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_READ, S_CHECK, S_RCFG, S_CMD, S_WAIT, S_WB, S_NEXT, S_DONE
  } state_e;

  localparam logic [INDEX_WIDTH-1:0]  LAST_IDX   = {INDEX_WIDTH{1'b1}};
  localparam logic [STATUS_WIDTH-1:0] ST_PENDING = STATUS_WIDTH'(1);
  localparam logic [STATUS_WIDTH-1:0] ST_DONE    = STATUS_WIDTH'(2);
  localparam logic [STATUS_WIDTH-1:0] ST_ERROR   = STATUS_WIDTH'(3);

  state_e                   state_q, state_d;
  logic [INDEX_WIDTH-1:0]   cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]    addr_q, addr_d;
  logic [SIZE_WIDTH-1:0]    size_q, size_d;
  logic [PROFILE_WIDTH-1:0] prof_q, prof_d;
  logic [PROFILE_WIDTH-1:0] ld_prof_q, ld_prof_d;
  logic                     ld_vld_q, ld_vld_d;
  logic [INDEX_WIDTH-1:0]   wr_index_q, wr_index_d;
  logic [STATUS_WIDTH-1:0]  wr_status_q, wr_status_d;
  logic                     busy_q, busy_d;
  logic                     pass_done_q, pass_done_d;
  logic                     rcfg_req_q, rcfg_req_d;
  logic                     cmd_valid_q, cmd_valid_d;
  logic                     wr_set_q, wr_set_d;
`ifdef SLOT_DISP_LOOP_EN
  logic                     stop_seen_q, stop_seen_d;
  logic                     wrap_c;
`endif

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      size_q      <= '0;
      prof_q      <= '0;
      ld_prof_q   <= '0;
      ld_vld_q    <= 1'b0;
      wr_index_q  <= '0;
      wr_status_q <= '0;
      busy_q      <= 1'b0;
      pass_done_q <= 1'b0;
      rcfg_req_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      wr_set_q    <= 1'b0;
`ifdef SLOT_DISP_LOOP_EN
      stop_seen_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      size_q      <= size_d;
      prof_q      <= prof_d;
      ld_prof_q   <= ld_prof_d;
      ld_vld_q    <= ld_vld_d;
      wr_index_q  <= wr_index_d;
      wr_status_q <= wr_status_d;
      busy_q      <= busy_d;
      pass_done_q <= pass_done_d;
      rcfg_req_q  <= rcfg_req_d;
      cmd_valid_q <= cmd_valid_d;
      wr_set_q    <= wr_set_d;
`ifdef SLOT_DISP_LOOP_EN
      stop_seen_q <= stop_seen_d;
`endif
    end
  end

  // Next state and datapath updates
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    size_d      = size_q;
    prof_d      = prof_q;
    ld_prof_d   = ld_prof_q;
    ld_vld_d    = ld_vld_q;
    wr_index_d  = wr_index_q;
    wr_status_d = wr_status_q;
`ifdef SLOT_DISP_LOOP_EN
    stop_seen_d = stop_seen_q | (stop & (state_q != S_IDLE));
    wrap_c      = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_READ;
          cnt_d   = '0;
`ifdef SLOT_DISP_LOOP_EN
          stop_seen_d = stop;
`endif
        end
      end
      S_READ: begin
        addr_d  = bus.rd_addr;
        size_d  = bus.rd_size;
        prof_d  = bus.rd_profile;
        state_d = (bus.rd_status == ST_PENDING) ? S_CHECK : S_NEXT;
      end
      S_CHECK: begin
        state_d = (ld_vld_q && (ld_prof_q == prof_q)) ? S_CMD : S_RCFG;
      end
      S_RCFG: begin
        if (bus.rcfg_ack) begin
          ld_prof_d = prof_q;
          ld_vld_d  = 1'b1;
          state_d   = S_CMD;
        end
      end
      S_CMD: begin
        if (bus.cmd_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.cmd_done) begin
          wr_status_d = bus.cmd_err ? ST_ERROR : ST_DONE;
          wr_index_d  = cnt_q;
          state_d     = S_WB;
        end
      end
      S_WB: state_d = S_NEXT;
      S_NEXT: begin
        if (cnt_q == LAST_IDX) begin
`ifdef SLOT_DISP_LOOP_EN
          // Keep sweeping until stop has been observed during the run
          if (stop_seen_q || stop) begin
            state_d = S_DONE;
          end else begin
            cnt_d   = '0;
            wrap_c  = 1'b1;
            state_d = S_READ;
          end
`else
          state_d = S_DONE;
`endif
        end else begin
          cnt_d   = cnt_q + INDEX_WIDTH'(1);
          state_d = S_READ;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs registered from the state being entered
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    pass_done_d = (state_d == S_DONE);
`ifdef SLOT_DISP_LOOP_EN
    pass_done_d = pass_done_d | wrap_c;
`endif
    rcfg_req_d  = (state_d == S_RCFG);
    cmd_valid_d = (state_d == S_CMD);
    wr_set_d    = (state_d == S_WB);
  end

  assign busy              = busy_q;
  assign pass_done         = pass_done_q;
  assign bus.rd_index      = cnt_q;
  assign bus.wr_index      = wr_index_q;
  assign bus.wr_status     = wr_status_q;
  assign bus.wr_set_status = wr_set_q;
  assign bus.rcfg_req      = rcfg_req_q;
  assign bus.rcfg_profile  = prof_q;
  assign bus.cmd_valid     = cmd_valid_q;
  assign bus.cmd_addr      = addr_q;
  assign bus.cmd_size      = size_q;

endmodule

// File: tb/tb_slot_dispatcher.sv
// Scoreboard bench for slot_dispatcher: a slot-order reference model queues expected
// reconfigurations, commands and write-backs; a monitor pops them as the DUT produces them.
`timescale 1ns/1ps
module tb_slot_dispatcher;
  localparam int unsigned IW = 2, AW = 32, SW = 26, STW = 2, PW = 4;
  localparam int unsigned NSLOT = 1 << IW;

  typedef struct packed { logic [AW-1:0] a; logic [SW-1:0] s; } cmd_t;
  typedef struct packed { logic [IW-1:0] idx; logic [STW-1:0] st; } wr_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic busy, pass_done;
`ifdef SLOT_DISP_LOOP_EN
  logic stop = 1'b1;
`endif

  always #5 clk = ~clk;

  slot_dispatcher_if #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                       .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW)) bus ();

  slot_dispatcher #(.INDEX_WIDTH(IW), .ADDR_WIDTH(AW), .SIZE_WIDTH(SW),
                    .STATUS_WIDTH(STW), .PROFILE_WIDTH(PW)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .start     (start),
`ifdef SLOT_DISP_LOOP_EN
    .stop      (stop),
`endif
    .busy      (busy),
    .pass_done (pass_done),
    .bus       (bus)
  );

  // Slot table contents and per-slot DMA error outcome
  logic [AW-1:0]  t_addr [NSLOT];
  logic [SW-1:0]  t_size [NSLOT];
  logic [STW-1:0] t_st   [NSLOT];
  logic [PW-1:0]  t_prof [NSLOT];
  bit             t_err  [NSLOT];

  always_comb begin
    bus.rd_addr    = t_addr[bus.rd_index];
    bus.rd_size    = t_size[bus.rd_index];
    bus.rd_status  = t_st[bus.rd_index];
    bus.rd_profile = t_prof[bus.rd_index];
  end

  // Scoreboard queues and reference-model state
  logic [PW-1:0] exp_rcfg_q[$];
  cmd_t          exp_cmd_q[$];
  wr_t           exp_wr_q[$];
  bit            err_q[$];
  bit            m_vld = 1'b0;
  logic [PW-1:0] m_prof = '0;

  int unsigned n_checks = 0, n_fail = 0;
  int unsigned cyc = 0;
  int unsigned rcfg_hs_cnt = 0, cmd_hs_cnt = 0, wr_cnt = 0, pass_cnt = 0, pass_cyc = 0;
  int unsigned st_cyc = 0;

  int unsigned rdy_pct = 100, ack_pct = 100, done_max = 0, bp_cycles = 0;
  bit noise = 1'b0, dma_hold = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string nm, input logic [63:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s: unexpected event, got 0x%0h expected none (t=%0t)", nm, act, $time);
  endtask

  // Reference model: slots in index order, only PENDING ones produce traffic
  task automatic model_pass();
    for (int i = 0; i < NSLOT; i++) begin
      if (t_st[i] == STW'(1)) begin
        if (!m_vld || m_prof != t_prof[i]) begin
          exp_rcfg_q.push_back(t_prof[i]);
          m_prof = t_prof[i];
          m_vld  = 1'b1;
        end
        exp_cmd_q.push_back('{a: t_addr[i], s: t_size[i]});
        err_q.push_back(t_err[i]);
        exp_wr_q.push_back('{idx: IW'(i), st: t_err[i] ? STW'(3) : STW'(2)});
      end
    end
  endtask

  // Environment responders: DFX ack, DMA ready, DMA completion
  initial begin : slave_drv
    bit hs, out_pend, out_err;
    int unsigned dly, vcyc;
    bus.rcfg_ack = 1'b0; bus.cmd_ready = 1'b0; bus.cmd_done = 1'b0; bus.cmd_err = 1'b0;
    out_pend = 1'b0; out_err = 1'b0; dly = 0; vcyc = 0;
    forever begin
      @(negedge clk);
      hs = bus.cmd_valid && bus.cmd_ready && rst_n;
      if (!rst_n) out_pend = 1'b0;
      @(posedge clk); #1;
      if (hs) begin
        out_pend = 1'b1;
        dly      = $urandom_range(done_max, 0);
        out_err  = (err_q.size() > 0) ? err_q.pop_front() : 1'b0;
      end
      if (out_pend && !dma_hold) begin
        if (dly == 0) begin
          bus.cmd_done = 1'b1; bus.cmd_err = out_err; out_pend = 1'b0;
        end else begin
          dly--;
          bus.cmd_done = 1'b0;
          bus.cmd_err  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
        end
      end else begin
        bus.cmd_done = (noise && bus.cmd_valid && !out_pend) ? ($urandom_range(99, 0) < 30) : 1'b0;
        bus.cmd_err  = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      end
      vcyc = bus.cmd_valid ? vcyc + 1 : 0;
      if (bus.cmd_valid)
        bus.cmd_ready = (vcyc > bp_cycles) && ($urandom_range(99, 0) < rdy_pct);
      else
        bus.cmd_ready = noise ? 1'($urandom_range(1, 0)) : 1'b0;
      if (bus.rcfg_req)
        bus.rcfg_ack = ($urandom_range(99, 0) < ack_pct);
      else
        bus.rcfg_ack = noise ? 1'($urandom_range(1, 0)) : 1'b0;
    end
  end

  // Monitor: pops expectations as handshakes and strobes appear
  initial begin : monitor
    bit pv, pr;
    logic [AW-1:0] pa;
    logic [SW-1:0] ps;
    logic [PW-1:0] pp;
    pv = 1'b0; pr = 1'b0; pa = '0; ps = '0; pp = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pv = 1'b0; pr = 1'b0;
      end else begin
        if (pr) begin
          chk("rcfg_req_held", bus.rcfg_req, 1'b1);
          chk("rcfg_profile_stable", bus.rcfg_profile, pp);
        end
        if (bus.rcfg_req && bus.rcfg_ack) begin
          rcfg_hs_cnt++;
          if (exp_rcfg_q.size() == 0) unexpected("rcfg", bus.rcfg_profile);
          else chk("rcfg_profile", bus.rcfg_profile, exp_rcfg_q.pop_front());
        end
        pr = bus.rcfg_req && !bus.rcfg_ack;
        pp = bus.rcfg_profile;
        if (pv) begin
          chk("cmd_valid_held", bus.cmd_valid, 1'b1);
          chk("cmd_addr_stable", bus.cmd_addr, pa);
          chk("cmd_size_stable", bus.cmd_size, ps);
        end
        if (bus.cmd_valid && bus.cmd_ready) begin
          cmd_hs_cnt++;
          if (exp_cmd_q.size() == 0) unexpected("cmd", bus.cmd_addr);
          else chk("cmd_payload", {bus.cmd_addr, bus.cmd_size}, exp_cmd_q.pop_front());
        end
        pv = bus.cmd_valid && !bus.cmd_ready;
        pa = bus.cmd_addr;
        ps = bus.cmd_size;
        if (bus.wr_set_status) begin
          wr_cnt++;
          if (exp_wr_q.size() == 0) unexpected("wr_set_status", {bus.wr_index, bus.wr_status});
          else chk("wr_index_status", {bus.wr_index, bus.wr_status}, exp_wr_q.pop_front());
        end
        if (pass_done) begin
          pass_cnt++;
          pass_cyc = cyc;
        end
      end
    end
  end

  task automatic tick(input int unsigned n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_table();
    for (int i = 0; i < NSLOT; i++) begin
      t_addr[i] = '0; t_size[i] = '0; t_st[i] = '0; t_prof[i] = '0; t_err[i] = 1'b0;
    end
  endtask

  task automatic set_slot(input int i, input logic [AW-1:0] a, input logic [SW-1:0] s,
                          input logic [STW-1:0] st, input logic [PW-1:0] p, input bit e);
    t_addr[i] = a; t_size[i] = s; t_st[i] = st; t_prof[i] = p; t_err[i] = e;
  endtask

  task automatic start_pass();
    model_pass();
    start  = 1'b1;
    st_cyc = cyc;
    tick();
    start  = 1'b0;
  endtask

  task automatic wait_pass(input int unsigned p0, input bit poke);
    for (int k = 0; k < 3000 && pass_cnt == p0; k++) begin
      if (poke && busy && $urandom_range(99, 0) < 5) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end else begin
        tick();
      end
    end
    if (pass_cnt == p0) begin
      n_checks++;
      n_fail++;
      $display("FAIL pass_timeout: got no pass_done expected one within 3000 cycles");
    end
    tick(3);
    chk("busy_after_pass", busy, 1'b0);
    chk("pass_done_count", pass_cnt - p0, 1);
    chk("rcfg_q_drained", exp_rcfg_q.size(), 0);
    chk("cmd_q_drained", exp_cmd_q.size(), 0);
    chk("wr_q_drained", exp_wr_q.size(), 0);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_pass_done"}, pass_done, 1'b0);
    chk({tag, "_rd_index"}, bus.rd_index, 0);
    chk({tag, "_wr_set_status"}, bus.wr_set_status, 1'b0);
    chk({tag, "_wr_index"}, bus.wr_index, 0);
    chk({tag, "_wr_status"}, bus.wr_status, 0);
    chk({tag, "_rcfg_req"}, bus.rcfg_req, 1'b0);
    chk({tag, "_rcfg_profile"}, bus.rcfg_profile, 0);
    chk({tag, "_cmd_valid"}, bus.cmd_valid, 1'b0);
    chk({tag, "_cmd_addr"}, bus.cmd_addr, 0);
    chk({tag, "_cmd_size"}, bus.cmd_size, 0);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got no end of test expected completion before 2 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int unsigned p0, c0, r0, w0;
    clear_table();
    tick(3);
    chk_outputs_zero("reset");
    rst_n = 1'b1;
    tick(2);

    // One pending slot, everything responds immediately
    set_slot(2, 32'h1000, 26'd64, 2'd1, 4'd3, 1'b0);
    p0 = pass_cnt;
    start_pass();
    wait_pass(p0, 1'b0);

    // Two slots sharing a profile reconfigure once
    clear_table();
    set_slot(0, 32'h2000, 26'd16, 2'd1, 4'd5, 1'b0);
    set_slot(1, 32'h3000, 26'd32, 2'd1, 4'd5, 1'b0);
    r0 = rcfg_hs_cnt; p0 = pass_cnt;
    start_pass();
    wait_pass(p0, 1'b0);
    chk("reuse_rcfg_count", rcfg_hs_cnt - r0, 1);

    // Error on slot 1, pass continues to slot 3
    clear_table();
    set_slot(1, 32'h4000, 26'd8, 2'd1, 4'd5, 1'b1);
    set_slot(3, 32'h5000, 26'd0, 2'd1, 4'd6, 1'b0);
    p0 = pass_cnt;
    start_pass();
    wait_pass(p0, 1'b0);

    // Backpressure: ready withheld for 10 cycles
    clear_table();
    set_slot(0, 32'hCAFE_0000, 26'h155_5555, 2'd1, 4'd6, 1'b0);
    bp_cycles = 10; c0 = cmd_hs_cnt; p0 = pass_cnt;
    start_pass();
    wait_pass(p0, 1'b0);
    chk("bp_handshakes", cmd_hs_cnt - c0, 1);
    bp_cycles = 0;

    // Nothing pending: no traffic, fixed latency
    clear_table();
    t_st[0] = 2'd0; t_st[1] = 2'd2; t_st[2] = 2'd0; t_st[3] = 2'd2;
    c0 = cmd_hs_cnt; r0 = rcfg_hs_cnt; w0 = wr_cnt; p0 = pass_cnt;
    start_pass();
    wait_pass(p0, 1'b0);
    chk("empty_pass_latency", pass_cyc - st_cyc, 2 * NSLOT + 1);
    chk("empty_no_traffic", (cmd_hs_cnt - c0) + (rcfg_hs_cnt - r0) + (wr_cnt - w0), 0);

    // Reset while waiting for DMA completion
    clear_table();
    set_slot(0, 32'h7000, 26'd128, 2'd1, 4'd7, 1'b0);
    dma_hold = 1'b1; c0 = cmd_hs_cnt; w0 = wr_cnt; p0 = pass_cnt;
    start_pass();
    for (int k = 0; k < 200 && cmd_hs_cnt == c0; k++) tick();
    chk("reset_test_cmd_issued", cmd_hs_cnt - c0, 1);
    tick(2);
    rst_n = 1'b0;
    @(negedge clk);
    chk_outputs_zero("midreset");
    exp_rcfg_q.delete(); exp_cmd_q.delete(); exp_wr_q.delete(); err_q.delete();
    m_vld = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    dma_hold = 1'b0;
    tick(4);
    chk("no_wb_after_reset", wr_cnt - w0, 0);
    chk("no_pass_after_reset", pass_cnt - p0, 0);
    chk("idle_after_reset", busy, 1'b0);
    r0 = rcfg_hs_cnt; p0 = pass_cnt;
    start_pass();
    wait_pass(p0, 1'b0);
    chk("rcfg_after_reset", rcfg_hs_cnt - r0, 1);

    // Randomized tables, responder timing and ignored-input noise
    noise = 1'b1;
    for (int n = 0; n < 25; n++) begin
      rdy_pct  = $urandom_range(100, 30);
      ack_pct  = $urandom_range(100, 30);
      done_max = $urandom_range(4, 0);
      for (int i = 0; i < NSLOT; i++)
        set_slot(i, $urandom, ($urandom_range(5, 0) == 0) ? '0 : SW'($urandom),
                 STW'($urandom_range(3, 0)), PW'($urandom_range(2, 0)),
                 ($urandom_range(3, 0) == 0));
      p0 = pass_cnt;
      start_pass();
      wait_pass(p0, 1'b1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
